// File: rtl/pc_pkg.sv
// Shared widths, FSM state encoding and the branch-target table for the fetch unit.
package pc_pkg;

  localparam int PW = 16;
  localparam int LW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Entries are two's-complement when used as relative offsets.
  localparam logic [15:0] LUT [0:7] = '{
    16'h0000, 16'h0008, 16'hFFFD, 16'h0010,
    16'hFFF0, 16'h0020, 16'h0002, 16'hFFFF
  };

endpackage

// File: rtl/pc_lut.sv
// Combinational branch-target lookup; the 16-bit entry is sign-extended or
// truncated to the PC width.
module pc_lut #(
  parameter int PW = pc_pkg::PW,
  parameter int LW = pc_pkg::LW
) (
  input  logic [LW-1:0] Lut_idx,
  output logic [PW-1:0] target
);
  import pc_pkg::*;

  logic signed [15:0] raw;

  // Table read
  always_comb begin
    raw = LUT[Lut_idx];
  end

  assign target = PW'(raw);

endmodule

// File: rtl/pc_fetch.sv
// Program-counter sequencer: IDLE/RUN/DONE control with halt, stall,
// absolute/relative branch and a saturating RUN-cycle counter.
module pc_fetch #(
  parameter int PW = pc_pkg::PW,
  parameter int LW = pc_pkg::LW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Halt,
  input  logic          Stall,
  input  logic          Branch_abs,
  input  logic          Branch_rel,
  input  logic [LW-1:0] Lut_idx,
  output logic [PW-1:0] PC,
  output logic          Running,
  output logic          Done,
  output logic [15:0]   Cycle_cnt
);
  import pc_pkg::*;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] pc_nxt;
  logic          done_nxt;
  logic [15:0]   cnt_nxt;
  logic [PW-1:0] target;

  pc_lut #(.PW(PW), .LW(LW)) u_lut (
    .Lut_idx (Lut_idx),
    .target  (target)
  );

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = RUN;  else state_nxt = IDLE;
      RUN:     if (Halt)  state_nxt = DONE; else state_nxt = RUN;
      DONE:    if (Start) state_nxt = RUN;  else state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    Running = 1'b0;
    case (state)
      RUN:     Running = 1'b1;
      default: Running = 1'b0;
    endcase
  end

  // Datapath next values; RUN applies one update in priority order
  always_comb begin
    pc_nxt   = PC;
    done_nxt = Done;
    cnt_nxt  = Cycle_cnt;
    case (state)
      IDLE, DONE: begin
        if (Start) begin
          pc_nxt   = '0;
          done_nxt = 1'b0;
          cnt_nxt  = 16'd0;
        end else begin
          pc_nxt   = PC;
        end
      end
      RUN: begin
        if (Cycle_cnt != 16'hFFFF) cnt_nxt = Cycle_cnt + 16'd1;
        else                       cnt_nxt = Cycle_cnt;
        if (Halt) begin
          done_nxt = 1'b1;
          pc_nxt   = PC;
        end else if (Stall) begin
          pc_nxt = PC;
        end else if (Branch_abs) begin
          pc_nxt = target;
        end else if (Branch_rel) begin
          pc_nxt = PC + target;
        end else begin
          pc_nxt = PC + PW'(1);
        end
      end
      default: begin
        pc_nxt = PC;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      PC        <= '0;
      Done      <= 1'b0;
      Cycle_cnt <= 16'd0;
    end else begin
      PC        <= pc_nxt;
      Done      <= done_nxt;
      Cycle_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch.
module tb_pc_fetch;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Halt;
  logic        Stall;
  logic        Branch_abs;
  logic        Branch_rel;
  logic [2:0]  Lut_idx;
  logic [15:0] PC;
  logic        Running;
  logic        Done;
  logic [15:0] Cycle_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  pc_fetch dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Halt       (Halt),
    .Stall      (Stall),
    .Branch_abs (Branch_abs),
    .Branch_rel (Branch_rel),
    .Lut_idx    (Lut_idx),
    .PC         (PC),
    .Running    (Running),
    .Done       (Done),
    .Cycle_cnt  (Cycle_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic ctl(input logic s, input logic h, input logic st,
                     input logic ba, input logic br, input logic [2:0] idx);
    Start = s; Halt = h; Stall = st; Branch_abs = ba; Branch_rel = br; Lut_idx = idx;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] pc, input logic run,
                         input logic dn, input logic [15:0] cnt);
    check_eq({tag, ".pc"},   32'(PC),        32'(pc));
    check_eq({tag, ".run"},  32'(Running),   32'(run));
    check_eq({tag, ".done"}, 32'(Done),      32'(dn));
    check_eq({tag, ".cnt"},  32'(Cycle_cnt), 32'(cnt));
  endtask

  initial begin
    Reset = 1'b1;
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    chk_all("reset", 16'h0000, 1'b0, 1'b0, 16'd0);
    Reset = 1'b0;
    tick();
    chk_all("idle", 16'h0000, 1'b0, 1'b0, 16'd0);

    // Start and four plain increments
    ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    chk_all("start", 16'h0000, 1'b1, 1'b0, 16'd0);
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_eq("inc.pc", 32'(PC), 32'(i));
    end
    chk_all("inc4", 16'h0004, 1'b1, 1'b0, 16'd4);
    repeat (3) tick();
    chk_all("inc7", 16'h0007, 1'b1, 1'b0, 16'd7);

    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
    tick();
    chk_all("rel_neg", 16'h0004, 1'b1, 1'b0, 16'd8);
    ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1);
    tick();
    chk_all("abs_prio", 16'h0008, 1'b1, 1'b0, 16'd9);
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
    tick();
    chk_all("rel_to5", 16'h0005, 1'b1, 1'b0, 16'd10);
    ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3);
    tick();
    chk_all("stall", 16'h0005, 1'b1, 1'b0, 16'd11);
    ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    chk_all("halt", 16'h0005, 1'b0, 1'b1, 16'd12);
    ctl(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5);
    tick();
    chk_all("done_hold", 16'h0005, 1'b0, 1'b1, 16'd12);

    // Restart from DONE, then wrap boundaries
    ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    chk_all("restart", 16'h0000, 1'b1, 1'b0, 16'd0);
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7);
    tick();
    chk_all("rel_ffff", 16'hFFFF, 1'b1, 1'b0, 16'd1);
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    chk_all("wrap", 16'h0000, 1'b1, 1'b0, 16'd2);
    repeat (5) tick();
    check_eq("pc5", 32'(PC), 32'h5);
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4);
    tick();
    chk_all("rel_fff5", 16'hFFF5, 1'b1, 1'b0, 16'd8);
    ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5);
    tick();
    chk_all("abs_20", 16'h0020, 1'b1, 1'b0, 16'd9);
    ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    chk_all("start_in_run", 16'h0021, 1'b1, 1'b0, 16'd10);

    // Mid-run asynchronous reset at PC=9
    ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
    tick();
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    chk_all("pc9", 16'h0009, 1'b1, 1'b0, 16'd12);
    #2;
    Reset = 1'b1;
    #1;
    chk_all("async_rst", 16'h0000, 1'b0, 1'b0, 16'd0);
    @(negedge Clk);
    ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    chk_all("rst_over_start", 16'h0000, 1'b0, 1'b0, 16'd0);
    Reset = 1'b0;
    ctl(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd5);
    tick();
    chk_all("idle_ignore", 16'h0000, 1'b0, 1'b0, 16'd0);

    // Long run: counter saturates, PC keeps wrapping
    ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    repeat (65534) @(posedge Clk);
    @(negedge Clk);
    chk_all("n65534", 16'hFFFE, 1'b1, 1'b0, 16'hFFFE);
    tick();
    chk_all("n65535", 16'hFFFF, 1'b1, 1'b0, 16'hFFFF);
    repeat (4465) @(posedge Clk);
    @(negedge Clk);
    chk_all("n70000", 16'd4464, 1'b1, 1'b0, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter PW, default 16, sets the program-counter width that addresses the instruction ROM.
REQ-002 Parameter LW, default 3, sets the branch-target LUT index width.
REQ-003 Clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Start  input  1  level, sampled on Clk; launches program execution from PC 0.
REQ-006 Halt  input  1  decoded halt instruction at current PC.
REQ-007 Stall  input  1  hold the current PC this cycle.
REQ-008 Branch_abs  input  1  take an absolute branch to LUT[Lut_idx].
REQ-009 Branch_rel  input  1  take a relative branch to PC + LUT[Lut_idx].
REQ-010 Lut_idx  input  LW  branch-target LUT index from the instruction field.
REQ-011 PC  output  PW  registered instruction-ROM address.
REQ-012 Running  output  1  high exactly while state is RUN.
REQ-013 Done  output  1  registered; high while state is DONE.
REQ-014 Cycle_cnt  output  16  registered count of RUN cycles since the last Start.

Function
REQ-015 The block SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE: PC held; Start=1 at an edge SHALL load PC=0, clear Cycle_cnt, and enter RUN.
REQ-017 RUN: each edge SHALL apply exactly one update, priority Halt > Stall > Branch_abs > Branch_rel > increment.
REQ-018 Halt=1 in RUN: PC held, Cycle_cnt increments, state goes to DONE, Done=1 from that edge.
REQ-019 Stall=1 (no Halt): PC held, Cycle_cnt increments, any branch request is ignored.
REQ-020 Branch_abs: PC <= LUT[Lut_idx]; Branch_abs and Branch_rel both high SHALL take the absolute branch.
REQ-021 Branch_rel: PC <= (PC + LUT[Lut_idx]) mod 2^PW, with the LUT value read as two's complement.
REQ-022 Increment: PC <= (PC + 1) mod 2^PW; 0xFFFF SHALL wrap to 0x0000.
REQ-023 Cycle_cnt SHALL increment once per RUN edge, saturate at 0xFFFF, and hold in IDLE and DONE.
REQ-024 Start in RUN SHALL be ignored.
REQ-025 Start=1 in DONE SHALL restart exactly as from IDLE (PC=0, Cycle_cnt=0, Done=0, enter RUN) on the same edge.
REQ-026 Halt, Stall, and branch inputs SHALL be ignored in IDLE and DONE.
REQ-027 PC SHALL reach the ROM one cycle after the deciding edge; ROM read is combinational, so the instruction is valid in the same cycle as the new PC.
REQ-028 LUT contents, indices 0..7: 0x0000, 0x0008, 0xFFFD, 0x0010, 0xFFF0, 0x0020, 0x0002, 0xFFFF.

Reset
REQ-029 Reset=1 SHALL immediately force state IDLE, PC=0, Done=0, Cycle_cnt=0; Running=0 follows.
REQ-030 Reset asserted mid-RUN SHALL abort the program; after release, the block waits in IDLE for Start.
REQ-031 Reset SHALL dominate Start at the same edge.

Structure
REQ-032 Package pc_pkg SHALL hold PW, LW, the state enum typedef (IDLE, RUN, DONE), and the LUT constant array.
REQ-033 The target LUT SHALL be a separate combinational sub-module pc_lut (Lut_idx in, PW-bit target out); pc_fetch instantiates it once.
REQ-034 The only sequential elements SHALL be state, PC, Done, and Cycle_cnt.

Verification
REQ-035 Reset, Start pulse, no control for 4 edges -> PC 0,1,2,3,4; Running=1; Cycle_cnt=4.
REQ-036 At PC=7, Branch_rel=1, Lut_idx=2 -> PC=4; at PC=4, Branch_abs=1 and Branch_rel=1, Lut_idx=1 -> PC=8.
REQ-037 Stall=1 with Branch_abs=1 at PC=5 -> PC stays 5; Halt=1 with Stall=1 -> DONE, Done=1, PC held.
REQ-038 Force PC=0xFFFF via relative branch (PC=0, idx 7), then increment -> PC=0x0000; relative branch idx 4 at PC=0x0005 -> PC=0xFFF5.
REQ-039 Reset pulse mid-RUN at PC=9 -> PC=0, Running=0 asynchronously; Start in DONE -> PC=0, Done=0, Cycle_cnt=0 next edge.
REQ-040 Run 70000 cycles without Halt -> Cycle_cnt saturates at 0xFFFF while PC keeps wrapping.
